// File: rtl/ecpri_pkg.sv
// Shared constants, opcode enums and FSM state type for the eCPRI receive path.
package ecpri_pkg;

  localparam logic [7:0] MSG_RMA       = 8'd4;
  localparam int         OFF_RMA_ID    = 4;
  localparam int         OFF_ADDR      = 8;
  localparam int         OFF_LEN       = 14;
  localparam int         RMA_HDR_BYTES = 12;

  typedef enum logic [3:0] {
    OP_READ     = 4'd0,
    OP_WRITE    = 4'd1,
    OP_WRITE_NR = 4'd2
  } rma_op_e;

  typedef enum logic [3:0] {
    RR_REQ  = 4'd0,
    RR_RESP = 4'd1
  } rma_rr_e;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_RMA_HDR,
    ST_WDATA,
    ST_DROP,
    ST_RESP
  } state_e;

endpackage

// File: rtl/ecpri_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module ecpri_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ecpri_rx_rma.sv
// eCPRI receive parser: validates the common header, executes RMA write payload
// into a local memory port and hands RMA responses to the transmit side.
//
// state      | meaning
// ST_HDR     | common header bytes b0..b3, decision at b3
// ST_RMA_HDR | RMA header bytes b4..b15, decision at b15
// ST_WDATA   | write payload, one memory strobe per byte
// ST_DROP    | discard remainder of a bad or ignored packet
// ST_RESP    | response request held until accepted
module ecpri_rx_rma
  import ecpri_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 12,
  parameter int ECPRI_REV  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_is_read,
  output logic [7:0]            resp_rma_id,
  output logic [15:0]           resp_element_id,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [LEN_WIDTH-1:0]  resp_len,
  output logic [CNT_WIDTH-1:0]  cnt_ok,
  output logic [CNT_WIDTH-1:0]  cnt_err,
  output logic [CNT_WIDTH-1:0]  cnt_ign
);

  localparam logic [3:0] IDX_HDR_DEC = 4'(OFF_RMA_ID - 1);
  localparam logic [3:0] IDX_RMA_DEC = 4'(OFF_LEN + 1);
  localparam int         SUM_W       = ADDR_WIDTH + 17;

  state_e               state, state_next;
  logic                 acc;
  logic [3:0]           idx;
  logic [3:0]           rev_q;
  logic                 c_q;
  logic [7:0]           type_q;
  logic [15:0]          p_q;
  logic [7:0]           rma_id_q;
  logic [7:0]           op_q;
  logic [15:0]          elem_q;
  logic [47:0]          addr_q;
  logic [15:0]          len_q;
  logic [LEN_WIDTH-1:0] k_q;
  logic                 drop_err_q;

  logic                 inc_ok, inc_err, inc_ign;
  logic                 resp_load, wr_en, drop_set, drop_as_err;
  logic [15:0]          len_cur;
  logic [3:0]           op_f, rr_f;
  logic                 hdr_err, rma_err, last_k;
  logic [SUM_W-1:0]     end_addr, addr_lim;
  logic [16:0]          p_exp;

  assign acc        = in_valid && in_ready;
  assign in_ready   = (state != ST_RESP);
  assign resp_valid = (state == ST_RESP);

  assign op_f     = op_q[7:4];
  assign rr_f     = op_q[3:0];
  assign len_cur  = {len_q[15:8], in_data};
  assign hdr_err  = (rev_q != 4'(ECPRI_REV)) || c_q;
  assign end_addr = SUM_W'(addr_q[ADDR_WIDTH-1:0]) + SUM_W'(len_cur);
  assign addr_lim = SUM_W'(1) << ADDR_WIDTH;
  assign p_exp    = 17'(RMA_HDR_BYTES) + ((op_f == OP_READ) ? 17'd0 : 17'(len_cur));
  assign last_k   = (k_q == (len_q[LEN_WIDTH-1:0] - LEN_WIDTH'(1)));

  // Only meaningful on b15, where in_data carries the low length byte.
  assign rma_err = (rr_f != RR_REQ)
                || (op_f > OP_WRITE_NR)
                || ((addr_q >> ADDR_WIDTH) != 48'd0)
                || (len_cur == 16'd0)
                || (17'(len_cur) >= (17'd1 << LEN_WIDTH))
                || (end_addr > addr_lim)
                || (17'(p_q) != p_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_HDR;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    inc_ok      = 1'b0;
    inc_err     = 1'b0;
    inc_ign     = 1'b0;
    resp_load   = 1'b0;
    wr_en       = 1'b0;
    drop_set    = 1'b0;
    drop_as_err = 1'b1;
    case (state)
      ST_HDR: begin
        if (acc) begin
          if (idx == IDX_HDR_DEC) begin
            if (hdr_err) begin
              drop_set = 1'b1;
            end else if (type_q != MSG_RMA) begin
              drop_set    = 1'b1;
              drop_as_err = 1'b0;
            end else if (in_last) begin
              inc_err = 1'b1;
            end else begin
              state_next = ST_RMA_HDR;
            end
          end else if (in_last) begin
            inc_err = 1'b1;
          end
        end
      end
      ST_RMA_HDR: begin
        if (acc) begin
          if (idx == IDX_RMA_DEC) begin
            if (rma_err) begin
              drop_set = 1'b1;
            end else if (op_f == OP_READ) begin
              if (in_last) begin
                state_next = ST_RESP;
                resp_load  = 1'b1;
              end else begin
                drop_set = 1'b1;
              end
            end else if (in_last) begin
              inc_err    = 1'b1;
              state_next = ST_HDR;
            end else begin
              state_next = ST_WDATA;
            end
          end else if (in_last) begin
            inc_err    = 1'b1;
            state_next = ST_HDR;
          end
        end
      end
      ST_WDATA: begin
        if (acc) begin
          wr_en = 1'b1;
          if (in_last) begin
            if (!last_k) begin
              inc_err    = 1'b1;
              state_next = ST_HDR;
            end else if (op_f == OP_WRITE) begin
              state_next = ST_RESP;
              resp_load  = 1'b1;
            end else begin
              inc_ok     = 1'b1;
              state_next = ST_HDR;
            end
          end else if (last_k) begin
            drop_set = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (acc && in_last) begin
          inc_err    = drop_err_q;
          inc_ign    = !drop_err_q;
          state_next = ST_HDR;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          inc_ok     = 1'b1;
          state_next = ST_HDR;
        end
      end
      default: state_next = ST_HDR;
    endcase

    // A failing byte that is also the last one is counted immediately.
    if (drop_set) begin
      if (in_last) begin
        inc_err    = drop_as_err;
        inc_ign    = !drop_as_err;
        state_next = ST_HDR;
      end else begin
        state_next = ST_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      rev_q    <= '0;
      c_q      <= 1'b0;
      type_q   <= '0;
      p_q      <= '0;
      rma_id_q <= '0;
      op_q     <= '0;
      elem_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else if (acc && ((state == ST_HDR) || (state == ST_RMA_HDR))) begin
      idx <= (((state_next == ST_HDR) && !in_last) || (state_next == ST_RMA_HDR))
             ? idx + 4'd1 : 4'd0;
      case (idx)
        4'd0: begin
          rev_q <= in_data[7:4];
          c_q   <= in_data[0];
        end
        4'd1:             type_q        <= in_data;
        4'd2:             p_q[15:8]     <= in_data;
        4'd3:             p_q[7:0]      <= in_data;
        4'(OFF_RMA_ID):   rma_id_q      <= in_data;
        4'(OFF_RMA_ID+1): op_q          <= in_data;
        4'd6:             elem_q[15:8]  <= in_data;
        4'd7:             elem_q[7:0]   <= in_data;
        4'(OFF_LEN):      len_q[15:8]   <= in_data;
        4'(OFF_LEN+1):    len_q[7:0]    <= in_data;
        default:          addr_q        <= {addr_q[39:0], in_data};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q        <= '0;
      drop_err_q <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k_q);
        mem_wdata <= in_data;
      end
      if (state != ST_WDATA) k_q <= '0;
      else if (acc)          k_q <= k_q + LEN_WIDTH'(1);
      if (drop_set) drop_err_q <= drop_as_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_is_read    <= 1'b0;
      resp_rma_id     <= '0;
      resp_element_id <= '0;
      resp_addr       <= '0;
      resp_len        <= '0;
    end else if (resp_load) begin
      resp_is_read    <= (state == ST_RMA_HDR);
      resp_rma_id     <= rma_id_q;
      resp_element_id <= elem_q;
      resp_addr       <= addr_q[ADDR_WIDTH-1:0];
      resp_len        <= (state == ST_RMA_HDR) ? len_cur[LEN_WIDTH-1:0]
                                               : len_q[LEN_WIDTH-1:0];
    end
  end

  ecpri_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_ok (
    .clk(clk), .reset(reset), .inc(inc_ok), .count(cnt_ok)
  );

  ecpri_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_err (
    .clk(clk), .reset(reset), .inc(inc_err), .count(cnt_err)
  );

  ecpri_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_ign (
    .clk(clk), .reset(reset), .inc(inc_ign), .count(cnt_ign)
  );

endmodule

// File: tb/tb_ecpri_rx_rma.sv
// Directed bench for ecpri_rx_rma: hand-built packets with hand-computed results.
module tb_ecpri_rx_rma;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_is_read;
  logic [7:0]  resp_rma_id;
  logic [15:0] resp_element_id;
  logic [15:0] resp_addr;
  logic [11:0] resp_len;
  logic [15:0] cnt_ok, cnt_err, cnt_ign;

  int          n_assert = 0;
  int          n_fail = 0;
  int          wr_n = 0;
  int          wr_base;
  logic [15:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  bq_t         pkt;

  ecpri_rx_rma #(
    .ADDR_WIDTH(16), .LEN_WIDTH(12), .ECPRI_REV(1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_read(resp_is_read),
    .resp_rma_id(resp_rma_id), .resp_element_id(resp_element_id),
    .resp_addr(resp_addr), .resp_len(resp_len),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err), .cnt_ign(cnt_ign)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input bq_t p, input bit mark_last, input bit hold_valid);
    for (int i = 0; i < p.size(); i++) begin
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = p[i];
      in_last  = mark_last && (i == p.size() - 1);
      while (!in_ready && guard < 20) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (guard >= 20) chk("in_ready_wait", in_ready, 1);
      @(posedge clk);
      #1;
    end
    if (!hold_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  initial begin
    cycles(2);
    reset = 1'b1;
    cycles(1);

    // reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_len", resp_len, 0);
    chk("rst_resp_rma_id", resp_rma_id, 0);
    chk("rst_cnt_ok", cnt_ok, 0);
    chk("rst_cnt_err", cnt_err, 0);
    chk("rst_cnt_ign", cnt_ign, 0);

    // write with response: L=4, A=0x10, P=16
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h10, 8'h5A, 8'h10, 8'h12, 8'h34,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h04,
            8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(pkt, 1, 0);
    chk("wr_resp_valid", resp_valid, 1);
    chk("wr_in_ready", in_ready, 0);
    chk("wr_is_read", resp_is_read, 0);
    chk("wr_rma_id", resp_rma_id, 8'h5A);
    chk("wr_elem", resp_element_id, 16'h1234);
    chk("wr_addr", resp_addr, 16'h0010);
    chk("wr_len", resp_len, 4);
    resp_ready = 1'b1;
    cycles(1);
    resp_ready = 1'b0;
    chk("wr_resp_drop", resp_valid, 0);
    chk("wr_cnt_ok", cnt_ok, 1);
    chk("wr_n", wr_n - wr_base, 4);
    chk("wr0_a", wr_addr[wr_base], 16'h0010);
    chk("wr0_d", wr_data[wr_base], 8'hAA);
    chk("wr1_a", wr_addr[wr_base+1], 16'h0011);
    chk("wr1_d", wr_data[wr_base+1], 8'hBB);
    chk("wr2_a", wr_addr[wr_base+2], 16'h0012);
    chk("wr2_d", wr_data[wr_base+2], 8'hCC);
    chk("wr3_a", wr_addr[wr_base+3], 16'h0013);
    chk("wr3_d", wr_data[wr_base+3], 8'hDD);

    // read with response held off for 5 cycles
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h0C, 8'h33, 8'h00, 8'hBE, 8'hEF,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h08};
    send_pkt(pkt, 1, 0);
    chk("rd_resp_valid", resp_valid, 1);
    chk("rd_is_read", resp_is_read, 1);
    chk("rd_len", resp_len, 8);
    chk("rd_addr", resp_addr, 16'h0100);
    chk("rd_elem", resp_element_id, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("rd_hold_in_ready", in_ready, 0);
      chk("rd_hold_valid", resp_valid, 1);
      chk("rd_hold_id", resp_rma_id, 8'h33);
    end
    resp_ready = 1'b1;
    cycles(1);
    resp_ready = 1'b0;
    chk("rd_cnt_ok", cnt_ok, 2);
    chk("rd_in_ready", in_ready, 1);
    chk("rd_no_writes", wr_n - wr_base, 0);

    // bad revision, then a write-no-resp back to back
    pkt = '{8'h20, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 1, 1);
    chk("rev_cnt_err", cnt_err, 1);
    chk("rev_in_ready", in_ready, 1);
    chk("rev_no_resp", resp_valid, 0);
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h0E, 8'h01, 8'h20, 8'h00, 8'h01,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h02,
            8'h11, 8'h22};
    send_pkt(pkt, 1, 0);
    chk("nr_cnt_ok", cnt_ok, 3);
    chk("nr_no_resp", resp_valid, 0);
    cycles(1);
    chk("nr_n", wr_n - wr_base, 2);
    chk("nr0_a", wr_addr[wr_base], 16'h0020);
    chk("nr1_d", wr_data[wr_base+1], 8'h22);

    // IQ data (type 0), 20 bytes
    pkt = '{8'h10, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
            8'h0D, 8'h0E, 8'h0F, 8'h10};
    send_pkt(pkt, 1, 0);
    chk("ign_cnt_ign", cnt_ign, 1);
    chk("ign_cnt_err", cnt_err, 1);
    chk("ign_in_ready", in_ready, 1);

    // early in_last on 2nd data byte
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h10, 8'h07, 8'h10, 8'h00, 8'h02,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h04,
            8'h01, 8'h02};
    send_pkt(pkt, 1, 0);
    chk("early_cnt_err", cnt_err, 2);
    chk("early_no_resp", resp_valid, 0);
    cycles(1);
    chk("early_n", wr_n - wr_base, 2);
    chk("early1_a", wr_addr[wr_base+1], 16'h0041);

    // address overflow: 0xFFFE + 4
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h10, 8'h08, 8'h10, 8'h00, 8'h03,
            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'h00, 8'h04,
            8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(pkt, 1, 0);
    chk("ovf_cnt_err", cnt_err, 3);
    chk("ovf_cnt_ok", cnt_ok, 3);
    cycles(1);
    chk("ovf_n", wr_n - wr_base, 0);

    // exact fit at top of memory: 0xFFFC + 4, write-no-resp
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h10, 8'h09, 8'h20, 8'h00, 8'h04,
            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFC, 8'h00, 8'h04,
            8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(pkt, 1, 0);
    chk("fit_cnt_ok", cnt_ok, 4);
    cycles(1);
    chk("fit_n", wr_n - wr_base, 4);
    chk("fit3_a", wr_addr[wr_base+3], 16'hFFFF);
    chk("fit3_d", wr_data[wr_base+3], 8'hA4);

    // reset mid-packet at b9
    wr_base = wr_n;
    pkt = '{8'h10, 8'h04, 8'h00, 8'h10, 8'h0A, 8'h10, 8'h00, 8'h05,
            8'h00, 8'h00};
    send_pkt(pkt, 0, 0);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    chk("rst2_cnt_ok", cnt_ok, 0);
    chk("rst2_cnt_err", cnt_err, 0);
    chk("rst2_cnt_ign", cnt_ign, 0);
    pkt = '{8'h10, 8'h04, 8'h00, 8'h0C, 8'h44, 8'h00, 8'h00, 8'h09,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01};
    send_pkt(pkt, 1, 0);
    chk("rst2_resp_valid", resp_valid, 1);
    chk("rst2_rma_id", resp_rma_id, 8'h44);
    chk("rst2_addr", resp_addr, 16'h0200);
    chk("rst2_len", resp_len, 1);
    resp_ready = 1'b1;
    cycles(1);
    resp_ready = 1'b0;
    chk("rst2_cnt_ok_after", cnt_ok, 1);
    chk("rst2_cnt_err_after", cnt_err, 0);
    chk("rst2_no_writes", wr_n - wr_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
